// File: rtl/ram_march_bist.sv
// March-test initiator for one RAM port: a simplified March C- in four phases.
// Read data is expected one enabled cycle after ARdEn (port-B style RAM).
// It reports pass/fail, a saturating error count and the first failing address/phase.
module ram_march_bist #(
  parameter int unsigned CAddrLen   = 8,
  parameter int unsigned CDataLen   = 8,
  parameter int unsigned CErrCntLen = 16
) (
  input  logic                  AClkH,
  input  logic                  AResetHN,
  input  logic                  AClkHEn,
  input  logic                  AStart,
  output logic                  ABusy,
  output logic                  ADone,
  output logic                  APass,
  output logic [CErrCntLen-1:0] AErrCnt,
  output logic [CAddrLen-1:0]   AErrAddr,
  output logic [1:0]            AErrPhase,
  output logic [CAddrLen-1:0]   AAddr,
  output logic [CDataLen-1:0]   AMosi,
  input  logic [CDataLen-1:0]   AMiso,
  output logic                  AWrEn,
  output logic                  ARdEn
);

  typedef enum logic [2:0] {StIdle, StP0, StP1, StP2, StP3, StDrain, StDone} state_e;

  localparam logic [CAddrLen-1:0] AddrMax = '1;

  state_e                state_q, state_d;
  logic [CAddrLen-1:0]   addr_q, addr_d;
  logic                  sub_q, sub_d;      // 0: read half, 1: write half of a P1/P2 pair
  logic                  wr_q, wr_d, rd_q, rd_d, busy_q, busy_d, done_q, done_d;
  logic [CDataLen-1:0]   mosi_q, mosi_d;
  logic [CErrCntLen-1:0] err_cnt_q, err_cnt_d;
  logic [CAddrLen-1:0]   err_addr_q, err_addr_d;
  logic [1:0]            err_phase_q, err_phase_d;
  // Pending read check, captured when ARdEn is high
  logic                  chk_flag_q, chk_flag_d;
  logic [CDataLen-1:0]   chk_exp_q, chk_exp_d;
  logic [CAddrLen-1:0]   chk_addr_q, chk_addr_d;
  logic [1:0]            chk_phase_q, chk_phase_d;
  logic                  start_ok, mismatch;

  // Sequencer next state and next registered outputs
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    sub_d    = sub_q;
    start_ok = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (AStart) begin
          start_ok = 1'b1;
          state_d  = StP0;
          addr_d   = '0;
          sub_d    = 1'b0;
        end
      end
      StP0: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == AddrMax) state_d = StP1;
      end
      StP1: begin
        sub_d = ~sub_q;
        if (sub_q) begin
          addr_d = addr_q + 1'b1;
          if (addr_q == AddrMax) begin
            state_d = StP2;
            addr_d  = AddrMax;
          end
        end
      end
      StP2: begin
        sub_d = ~sub_q;
        if (sub_q) begin
          addr_d = addr_q - 1'b1;
          if (addr_q == '0) begin
            state_d = StP3;
            addr_d  = '0;
          end
        end
      end
      StP3: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == AddrMax) state_d = StDrain;
      end
      StDrain: state_d = StDone;
      default: state_d = StIdle;
    endcase

    wr_d   = (state_d == StP0) || (((state_d == StP1) || (state_d == StP2)) && sub_d);
    rd_d   = (((state_d == StP1) || (state_d == StP2)) && !sub_d) || (state_d == StP3);
    mosi_d = ((state_d == StP1) && sub_d) ? '1 : '0;
    busy_d = (state_d != StIdle) && (state_d != StDone);
    done_d = (state_d == StDone);
  end

  // Read-check capture and error bookkeeping
  always_comb begin
    chk_flag_d  = rd_q;
    chk_exp_d   = (state_q == StP2) ? '1 : '0;
    chk_addr_d  = addr_q;
    chk_phase_d = (state_q == StP1) ? 2'd1 :
                  (state_q == StP2) ? 2'd2 :
                  (state_q == StP3) ? 2'd3 : 2'd0;
    mismatch    = chk_flag_q && (AMiso != chk_exp_q);
    err_cnt_d   = err_cnt_q;
    err_addr_d  = err_addr_q;
    err_phase_d = err_phase_q;
    if (start_ok) begin
      err_cnt_d   = '0;
      err_addr_d  = '0;
      err_phase_d = '0;
    end else if (mismatch) begin
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
      if (err_cnt_q == '0) begin
        err_addr_d  = chk_addr_q;
        err_phase_d = chk_phase_q;
      end
    end
  end

  // State and output registers; everything holds while AClkHEn is low
  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      sub_q       <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      mosi_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_cnt_q   <= '0;
      err_addr_q  <= '0;
      err_phase_q <= '0;
      chk_flag_q  <= 1'b0;
      chk_exp_q   <= '0;
      chk_addr_q  <= '0;
      chk_phase_q <= '0;
    end else if (AClkHEn) begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      sub_q       <= sub_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      mosi_q      <= mosi_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_cnt_q   <= err_cnt_d;
      err_addr_q  <= err_addr_d;
      err_phase_q <= err_phase_d;
      chk_flag_q  <= chk_flag_d;
      chk_exp_q   <= chk_exp_d;
      chk_addr_q  <= chk_addr_d;
      chk_phase_q <= chk_phase_d;
    end
  end

  assign ABusy     = busy_q;
  assign ADone     = done_q;
  assign APass     = done_q && (err_cnt_q == '0);
  assign AErrCnt   = err_cnt_q;
  assign AErrAddr  = err_addr_q;
  assign AErrPhase = err_phase_q;
  assign AAddr     = addr_q;
  assign AMosi     = mosi_q;
  assign AWrEn     = wr_q;
  assign ARdEn     = rd_q;

endmodule

// File: tb/tb_ram_march_bist.sv
// Bench for ram_march_bist: port-B style RAM model with one injectable stuck-at fault,
// a vector table of full runs, plus reset-abort and held-start sequences.
module tb_ram_march_bist;

  logic        AClkH = 1'b0;
  logic        AResetHN = 1'b0;
  logic        AClkHEn = 1'b1;
  logic        AStart = 1'b0;
  logic        ABusy, ADone, APass, AWrEn, ARdEn;
  logic [15:0] AErrCnt;
  logic [7:0]  AErrAddr, AAddr, AMosi, AMiso;
  logic [1:0]  AErrPhase;

  ram_march_bist dut (
    .AClkH    (AClkH),
    .AResetHN (AResetHN),
    .AClkHEn  (AClkHEn),
    .AStart   (AStart),
    .ABusy    (ABusy),
    .ADone    (ADone),
    .APass    (APass),
    .AErrCnt  (AErrCnt),
    .AErrAddr (AErrAddr),
    .AErrPhase(AErrPhase),
    .AAddr    (AAddr),
    .AMosi    (AMosi),
    .AMiso    (AMiso),
    .AWrEn    (AWrEn),
    .ARdEn    (ARdEn)
  );

  always #5 AClkH = ~AClkH;

  // RAM model with a stuck-at fault applied on reads of f_addr
  logic [7:0] mem [256];
  logic [7:0] rd_data = 8'h00;
  logic       rd_v = 1'b0;
  logic [7:0] f_addr = 8'h00, f_and = 8'hff, f_or = 8'h00;

  always @(posedge AClkH) begin
    if (AClkHEn) begin
      if (AWrEn) mem[AAddr] <= AMosi;
      rd_v <= ARdEn;
      if (ARdEn) rd_data <= (AAddr == f_addr) ? ((mem[AAddr] & f_and) | f_or) : mem[AAddr];
    end
  end
  assign AMiso = rd_v ? rd_data : 8'h00;

  int n_vec = 0;
  int n_miss = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {18'b0, ABusy, ADone, AErrCnt, AErrAddr, AErrPhase, AAddr, AMosi, AWrEn, ARdEn};
  endfunction

  task automatic do_reset();
    AResetHN = 1'b0;
    AStart   = 1'b0;
    AClkHEn  = 1'b1;
    @(negedge AClkH);
    @(negedge AClkH);
    AResetHN = 1'b1;
  endtask

  // Start on an enabled edge, then run until ADone (bounded)
  task automatic run_to_done(input bit toggle, input bit hold, output int clocks,
                             output int busy_cyc, output int overlap, output int hold_err);
    logic [63:0] snap;
    clocks = 0; busy_cyc = 0; overlap = 0; hold_err = 0;
    @(negedge AClkH);
    AClkHEn = 1'b1;
    AStart  = 1'b1;
    @(negedge AClkH);
    AStart = hold;
    while (!ADone && clocks < 4000) begin
      if (ABusy) busy_cyc++;
      if (AWrEn && ARdEn) overlap++;
      snap = outs();
      AClkHEn = toggle ? (clocks % 2 == 1) : 1'b1;
      @(negedge AClkH);
      clocks++;
      if (!AClkHEn && outs() != snap) hold_err++;
    end
    AClkHEn = 1'b1;
  endtask

  typedef struct {
    string      name;
    logic [7:0] f_addr;
    logic [7:0] f_and;
    logic [7:0] f_or;
    bit         toggle;
    int         exp_clocks;
    int         exp_cnt;
    int         exp_addr;
    int         exp_phase;
    int         exp_pass;
  } vec_t;

  vec_t vecs [4];
  int clocks, busy_cyc, overlap, hold_err;

  initial begin
    vecs[0] = '{"clean",    8'h00, 8'hff, 8'h00, 1'b0, 1537, 0, 8'h00, 0, 1};
    vecs[1] = '{"sa0_b3",   8'h12, 8'hf7, 8'h00, 1'b0, 1537, 1, 8'h12, 2, 0};
    vecs[2] = '{"sa1_b0",   8'h40, 8'hff, 8'h01, 1'b0, 1537, 2, 8'h40, 1, 0};
    vecs[3] = '{"en_tog",   8'h00, 8'hff, 8'h00, 1'b1, 3074, 0, 8'h00, 0, 1};

    // Reset state
    #1;
    check("reset_outs", int'(outs() != 64'd0), 0);
    check("reset_pass", int'(APass), 0);
    do_reset();

    foreach (vecs[i]) begin
      do_reset();
      f_addr = vecs[i].f_addr;
      f_and  = vecs[i].f_and;
      f_or   = vecs[i].f_or;
      run_to_done(vecs[i].toggle, 1'b0, clocks, busy_cyc, overlap, hold_err);
      check({vecs[i].name, "_clocks"}, clocks, vecs[i].exp_clocks);
      check({vecs[i].name, "_busy"}, busy_cyc, vecs[i].exp_clocks);
      check({vecs[i].name, "_done"}, int'(ADone), 1);
      check({vecs[i].name, "_busy_end"}, int'(ABusy), 0);
      check({vecs[i].name, "_pass"}, int'(APass), vecs[i].exp_pass);
      check({vecs[i].name, "_errcnt"}, int'(AErrCnt), vecs[i].exp_cnt);
      check({vecs[i].name, "_erraddr"}, int'(AErrAddr), vecs[i].exp_addr);
      check({vecs[i].name, "_errphase"}, int'(AErrPhase), vecs[i].exp_phase);
      check({vecs[i].name, "_rdwr_overlap"}, overlap, 0);
      check({vecs[i].name, "_hold"}, hold_err, 0);
    end

    // Reset asserted mid-P2 aborts asynchronously
    do_reset();
    f_addr = 8'h00; f_and = 8'hff; f_or = 8'h00;
    @(negedge AClkH);
    AStart = 1'b1;
    @(negedge AClkH);
    AStart = 1'b0;
    repeat (868) @(negedge AClkH);
    // 868 edges after start: P2 offset 100 -> address 255-50, read half
    check("midp2_busy", int'(ABusy), 1);
    check("midp2_addr", int'(AAddr), 205);
    check("midp2_rden", int'(ARdEn), 1);
    #2 AResetHN = 1'b0;
    #1;
    check("async_rst_outs", int'(outs() != 64'd0), 0);
    check("async_rst_pass", int'(APass), 0);
    @(negedge AClkH);
    AResetHN = 1'b1;
    run_to_done(1'b0, 1'b0, clocks, busy_cyc, overlap, hold_err);
    check("rerun_clocks", clocks, 1537);
    check("rerun_pass", int'(APass), 1);

    // AStart held high: no restart while busy, restart one enabled cycle after DONE
    do_reset();
    f_addr = 8'h40; f_and = 8'hff; f_or = 8'h01;
    run_to_done(1'b0, 1'b1, clocks, busy_cyc, overlap, hold_err);
    check("hold_clocks", clocks, 1537);
    check("hold_done", int'(ADone), 1);
    check("hold_errcnt", int'(AErrCnt), 2);
    @(negedge AClkH);
    check("restart_busy", int'(ABusy), 1);
    check("restart_done", int'(ADone), 0);
    check("restart_errcnt", int'(AErrCnt), 0);
    check("restart_addr", int'(AAddr), 0);
    check("restart_wren", int'(AWrEn), 1);
    AStart = 1'b0;
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
